serial_word_shifter: RTL and testbench

SERIAL_WORD_SHIFTER -- requirements
Module: serial_word_shifter

---
 rtl/serial_word_shifter_if.sv | 23 ++
 rtl/serial_word_shifter.sv | 98 +++++++++
 tb/tb_serial_word_shifter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/serial_word_shifter_if.sv
// Word-in / bit-out bundle for serial_word_shifter: upstream word handshake
// plus the serial bit stream and restart pulse for the downstream checker.
interface serial_word_shifter_if #(
    parameter int WIDTH = 8
);
    logic             word_valid;
    logic [WIDTH-1:0] word_data;
    logic             word_ready;
    logic             new_bit;
    logic             bit_valid;
    logic             bit_last;
    logic             word_clr;

    modport master (
        output word_valid, word_data,
        input  word_ready, new_bit, bit_valid, bit_last, word_clr
    );

    modport slave (
        input  word_valid, word_data,
        output word_ready, new_bit, bit_valid, bit_last, word_clr
    );
endinterface

// File: rtl/serial_word_shifter.sv
// Parallel-to-serial word shifter, MSB first, with back-to-back reload on the last bit.
// Define SERIAL_WORD_CLEAR_EN to insert a one-cycle word_clr restart before every word.
//
// state | meaning
// IDLE  | no word held; ready for a new word
// CLEAR | word_clr pulse to the downstream checker before shifting (SERIAL_WORD_CLEAR_EN only)
// SHIFT | presenting shift register MSB on new_bit; last bit when counter reaches 0
module serial_word_shifter #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_word_shifter_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef SERIAL_WORD_CLEAR_EN
    typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, SHIFT = 2'd2} state_t;
    localparam state_t FIRST = CLEAR;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd2} state_t;
    localparam state_t FIRST = SHIFT;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic ready, bit_out, valid_out, last_out, clr_out, load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        ready     = 1'b0;
        bit_out   = 1'b0;
        valid_out = 1'b0;
        last_out  = 1'b0;
        clr_out   = 1'b0;

        case (state_q)
            IDLE: begin
                ready = 1'b1;
            end
`ifdef SERIAL_WORD_CLEAR_EN
            CLEAR: begin
                clr_out = 1'b1;
                state_d = SHIFT;
            end
`endif
            SHIFT: begin
                valid_out = 1'b1;
                bit_out   = shreg_q[WIDTH-1];
                last_out  = (cnt_q == '0);
                ready     = last_out;
                shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                if (last_out) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase

        // A transfer overrides whatever the state would otherwise do next,
        // which gives the gapless reload when it lands on the last bit.
        load = bus.word_valid & ready;
        if (load) begin
            shreg_d = bus.word_data;
            cnt_d   = CW'(WIDTH - 1);
            state_d = FIRST;
        end
    end

    assign bus.word_ready = ready;
    assign bus.new_bit    = bit_out;
    assign bus.bit_valid  = valid_out;
    assign bus.bit_last   = last_out;
    assign bus.word_clr   = clr_out;
endmodule

// File: tb/tb_serial_word_shifter.sv
// Scoreboard bench for serial_word_shifter (WIDTH=8): senders queue expected bits
// with their cycle stamps, a negedge monitor pops and compares them.
module tb_serial_word_shifter;
    localparam int W = 8;
`ifdef SERIAL_WORD_CLEAR_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int   cyc;
        logic b;
        logic last;
        logic div;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_word_shifter_if #(.WIDTH(W)) bus ();
    serial_word_shifter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   rem = 0;
    exp_t q[$];
    int   clrq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send(input logic [7:0] w, input bit keep);
        int tries = 0;
        bus.word_valid = 1'b1;
        bus.word_data  = w;
        while (bus.word_ready !== 1'b1 && tries < 40) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 40) begin
            chk("send_timeout", tries, 0);
        end else begin
`ifdef SERIAL_WORD_CLEAR_EN
            clrq.push_back(cyc + 1);
`endif
            for (int i = 0; i < W; i++)
                q.push_back('{cyc + LAT + i, w[7-i], (i == W - 1), ((w % 3) == 0)});
        end
        @(negedge clk);
        if (!keep) bus.word_valid = 1'b0;
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_ready"},    bus.word_ready, 1);
        chk({tag, "_bitvalid"}, bus.bit_valid,  0);
        chk({tag, "_newbit"},   bus.new_bit,    0);
        chk({tag, "_bitlast"},  bus.bit_last,   0);
        chk({tag, "_wordclr"},  bus.word_clr,   0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (bus.word_clr === 1'b1) begin
                rem = 0;
                if (clrq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL clr_unexpected: word_clr high, none expected (cycle %0d)", cyc);
                end else begin
                    chk("clr_cycle", cyc, clrq.pop_front());
                end
            end else begin
                while (clrq.size() > 0 && clrq[0] <= cyc) begin
                    checks++; errors++;
                    $display("FAIL clr_missing: no word_clr, expected at cycle %0d", clrq.pop_front());
                end
            end

            if (bus.bit_valid === 1'b1) begin
                rem = (rem * 2 + int'(bus.new_bit)) % 3;
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bit_unexpected: bit_valid high, none expected (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("bit_cycle", cyc, e.cyc);
                    chk("new_bit",   bus.new_bit, e.b);
                    chk("bit_last",  bus.bit_last, e.last);
                    chk("ready_in_shift", bus.word_ready, e.last);
`ifdef SERIAL_WORD_CLEAR_EN
                    if (e.last) chk("div3_checker", (rem == 0), e.div);
`endif
                end
            end else begin
                chk("idle_new_bit",  bus.new_bit,  0);
                chk("idle_bit_last", bus.bit_last, 0);
                while (q.size() > 0 && q[0].cyc <= cyc) begin
                    e = q.pop_front();
                    checks++; errors++;
                    $display("FAIL bit_missing: bit_valid low, expected bit %0b at cycle %0d", e.b, e.cyc);
                end
            end
        end
    end

    initial begin
        bus.word_valid = 1'b0;
        bus.word_data  = '0;
        #1;
        idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // B4 straight out of reset
        send(8'hB4, 1'b0);
        repeat (10) @(negedge clk);

        // 0F then F0 with word_valid held: contiguous in the default build
        send(8'h0F, 1'b1);
        send(8'hF0, 1'b0);
        repeat (10) @(negedge clk);

        // FF, then data changes while shifting and must be ignored
        send(8'hFF, 1'b0);
        bus.word_data = 8'h00;
        repeat (12) @(negedge clk);
        chk("idle_after_ff_ready", bus.word_ready, 1);
        chk("idle_after_ff_valid", bus.bit_valid, 0);

        // Reset after the third bit of AA, then 55 must come out cleanly
        send(8'hAA, 1'b0);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        clrq.delete();
        #1;
        idle_outputs("midword_reset");
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h55, 1'b0);
        repeat (12) @(negedge clk);

        // 03 (divisible by 3) then 05 back-to-back
        send(8'h03, 1'b1);
        send(8'h05, 1'b0);
        repeat (14) @(negedge clk);

        chk("queue_drained", q.size() + clrq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
